array_search_ctrl: RTL and testbench

// - Sequencer for the parameterizable lane-compare datapath. It holds a DEPTH-entry key table and

---
 rtl/array_search_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_array_search_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/array_search_ctrl.sv
// array_search_ctrl
// Key-table search sequencer. Holds a DEPTH-entry table and compares it
// SIZE lanes per cycle against a latched key, reporting the lowest matching
// index. Optional macro ARRAY_SEARCH_COUNT_EN forces a full-table scan and
// adds the hit_cnt match counter; without it the scan stops at the first
// chunk that contains a match.
module array_search_ctrl #(
   parameter  int DEPTH  = 32,
   parameter  int SIZE   = 8,
   parameter  int WIDTH  = 4,
   localparam int NCHUNK = DEPTH / SIZE,
   localparam int AW     = $clog2(DEPTH),
   localparam int CW     = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   output logic             wr_err,
   input  logic             start,
   input  logic [WIDTH-1:0] key,
   output logic             busy,
   output logic             done,
   output logic             hit,
   output logic [AW-1:0]    hit_idx
`ifdef ARRAY_SEARCH_COUNT_EN
   ,
   output logic [CW-1:0]    hit_cnt
`endif
);

   // Chunk pointer needs at least one bit even for a single-chunk table
   localparam int CPW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [WIDTH-1:0] tbl [DEPTH];
   logic [WIDTH-1:0] key_q;
   logic [CPW-1:0]   chunk_q;

   // A write accepted in the same cycle as start must stay invisible to that
   // search, so the overwritten entry's old value is kept aside for the scan.
   logic             ovr_vld;
   logic [AW-1:0]    ovr_addr;
   logic [WIDTH-1:0] ovr_data;

   logic [SIZE-1:0]  mask;
   logic             any_match;
   logic [AW-1:0]    match_idx;
   logic             last_chunk;
   logic             scan_exit;
   logic             start_ok;

   logic             found_q;
   logic [AW-1:0]    found_idx_q;

   assign start_ok   = (state == IDLE) && start;
   assign last_chunk = (chunk_q == CPW'(NCHUNK - 1));
   assign busy       = (state == SCAN);
   assign done       = (state == DONE);
   assign wr_err     = wr_en && (state != IDLE);

   // Per-lane equality against the latched key; an unknown entry falls to the else path and never matches
   always_comb begin
      mask = '0;
      for (int l = 0; l < SIZE; l++) begin
         if (ovr_vld && (AW'(int'(chunk_q) * SIZE + l) == ovr_addr)) begin
            if (ovr_data == key_q) begin
               mask[l] = 1'b1;
            end
         end else if (tbl[AW'(int'(chunk_q) * SIZE + l)] == key_q) begin
            mask[l] = 1'b1;
         end
      end
   end

   // Priority-encode the lowest matching lane of the current chunk into a table index
   always_comb begin
      any_match = 1'b0;
      match_idx = '0;
      for (int l = SIZE - 1; l >= 0; l--) begin
         if (mask[l]) begin
            any_match = 1'b1;
            match_idx = AW'(int'(chunk_q) * SIZE + l);
         end
      end
   end

`ifdef ARRAY_SEARCH_COUNT_EN
   logic [CW-1:0] mask_cnt;

   // Population count of the current chunk's match mask
   always_comb begin
      mask_cnt = '0;
      for (int l = 0; l < SIZE; l++) begin
         mask_cnt = mask_cnt + CW'(mask[l]);
      end
   end

   // Counting mode must see every chunk, so only the last chunk ends the scan
   always_comb begin
      scan_exit = last_chunk;
   end

   // Match counter: cleared when a search is accepted, accumulates while scanning
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_cnt <= '0;
      end else if (start_ok) begin
         hit_cnt <= '0;
      end else if (state == SCAN) begin
         hit_cnt <= hit_cnt + mask_cnt;
      end
   end
`else
   // Early exit: the first chunk with any match already holds the lowest index
   always_comb begin
      scan_exit = last_chunk || any_match;
   end
`endif

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; start is only honoured in IDLE
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (start) state_nxt = SCAN;
         SCAN: if (scan_exit) state_nxt = DONE;
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Key table: host writes land only while idle; writes at other times are dropped
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            tbl[i] <= '0;
         end
      end else if (wr_en && (state == IDLE)) begin
         tbl[wr_addr] <= wr_data;
      end
   end

   // Search context: key, chunk pointer and shadow of a same-cycle write
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_q    <= '0;
         chunk_q  <= '0;
         ovr_vld  <= 1'b0;
         ovr_addr <= '0;
         ovr_data <= '0;
      end else if (start_ok) begin
         key_q    <= key;
         chunk_q  <= '0;
         ovr_vld  <= wr_en;
         ovr_addr <= wr_addr;
         ovr_data <= tbl[wr_addr];
      end else if ((state == SCAN) && !scan_exit) begin
         chunk_q  <= chunk_q + 1'b1;
      end
   end

   // Result tracking: the first matching chunk wins, results publish on the way into DONE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         found_q     <= 1'b0;
         found_idx_q <= '0;
         hit         <= 1'b0;
         hit_idx     <= '0;
      end else if (start_ok) begin
         found_q     <= 1'b0;
         found_idx_q <= '0;
      end else if (state == SCAN) begin
         if (any_match && !found_q) begin
            found_q     <= 1'b1;
            found_idx_q <= match_idx;
         end
         if (scan_exit) begin
            hit     <= found_q || any_match;
            hit_idx <= found_q ? found_idx_q : match_idx;
         end
      end
   end

endmodule

// File: tb/tb_array_search_ctrl.sv
// tb_array_search_ctrl
// Directed bench for array_search_ctrl (DEPTH=32, SIZE=8, WIDTH=4). Expected
// latencies and counts follow ARRAY_SEARCH_COUNT_EN when it is defined.
module tb_array_search_ctrl;

   localparam int DEPTH = 32;
   localparam int SIZE  = 8;
   localparam int WIDTH = 4;
   localparam int AW    = 5;
   localparam int CW    = 6;

`ifdef ARRAY_SEARCH_COUNT_EN
   localparam int LAT_C0 = 5;
   localparam int LAT_C2 = 5;
`else
   localparam int LAT_C0 = 2;
   localparam int LAT_C2 = 4;
`endif
   localparam int LAT_MISS = 5;
   localparam int LAT_MAX  = 20;

   logic             clk;
   logic             rst_n;
   logic             wr_en;
   logic [AW-1:0]    wr_addr;
   logic [WIDTH-1:0] wr_data;
   logic             wr_err;
   logic             start;
   logic [WIDTH-1:0] key;
   logic             busy;
   logic             done;
   logic             hit;
   logic [AW-1:0]    hit_idx;
`ifdef ARRAY_SEARCH_COUNT_EN
   logic [CW-1:0]    hit_cnt;
`endif

   int checks = 0;
   int errors = 0;
   int lat;
   int done_seen;

   array_search_ctrl #(
      .DEPTH(DEPTH),
      .SIZE (SIZE),
      .WIDTH(WIDTH)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .wr_en  (wr_en),
      .wr_addr(wr_addr),
      .wr_data(wr_data),
      .wr_err (wr_err),
      .start  (start),
      .key    (key),
      .busy   (busy),
      .done   (done),
      .hit    (hit),
      .hit_idx(hit_idx)
`ifdef ARRAY_SEARCH_COUNT_EN
      ,
      .hit_cnt(hit_cnt)
`endif
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic w_en, input logic [AW-1:0] w_addr,
                                input logic [WIDTH-1:0] w_data, input logic st,
                                input logic [WIDTH-1:0] k);
      wr_en   = w_en;
      wr_addr = w_addr;
      wr_data = w_data;
      start   = st;
      key     = k;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic writeEntry(input int addr, input int data);
      applyStimulus(1'b1, AW'(addr), WIDTH'(data), 1'b0, '0);
      tick();
      applyStimulus(1'b0, '0, '0, 1'b0, '0);
   endtask

   // Wait (bounded) for done; lat counts cycles after the start cycle
   task automatic waitDone(inout int l);
      while ((done !== 1'b1) && (l < LAT_MAX)) begin
         tick();
         l++;
      end
   endtask

   // Start a search in the current idle cycle and wait for its done pulse
   task automatic runSearch(input int k, output int l);
      applyStimulus(1'b0, '0, '0, 1'b1, WIDTH'(k));
      tick();
      applyStimulus(1'b0, '0, '0, 1'b0, '0);
      checkOutput("busy_after_start", {31'b0, busy}, 32'd1);
      l = 1;
      waitDone(l);
   endtask

   initial begin
      $display("[TB] start");
      applyStimulus(1'b0, '0, '0, 1'b0, '0);
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      checkOutput("reset_busy",    {31'b0, busy},   32'd0);
      checkOutput("reset_done",    {31'b0, done},   32'd0);
      checkOutput("reset_hit",     {31'b0, hit},    32'd0);
      checkOutput("reset_hit_idx", {27'b0, hit_idx}, 32'd0);
      checkOutput("reset_wr_err",  {31'b0, wr_err}, 32'd0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // entry[i] = i % 16, key 3 -> lowest index 3 (entries 3 and 19 match)
      for (int i = 0; i < DEPTH; i++) writeEntry(i, i % 16);
      runSearch(3, lat);
      checkOutput("k3_latency", lat, LAT_C0);
      checkOutput("k3_hit",     {31'b0, hit},    32'd1);
      checkOutput("k3_hit_idx", {27'b0, hit_idx}, 32'd3);
`ifdef ARRAY_SEARCH_COUNT_EN
      checkOutput("k3_hit_cnt", {26'b0, hit_cnt}, 32'd2);
`endif
      tick();
      checkOutput("k3_done_pulse", {31'b0, done}, 32'd0);

      // all zeros, key 9 -> full scan, no hit
      for (int i = 0; i < DEPTH; i++) writeEntry(i, 0);
      runSearch(9, lat);
      checkOutput("miss_latency", lat, LAT_MISS);
      checkOutput("miss_hit",     {31'b0, hit},    32'd0);
      checkOutput("miss_hit_idx", {27'b0, hit_idx}, 32'd0);
`ifdef ARRAY_SEARCH_COUNT_EN
      checkOutput("miss_hit_cnt", {26'b0, hit_cnt}, 32'd0);
`endif
      tick();

      // entries 17 and 30 = 0xA -> lowest index 17 in chunk 2
      writeEntry(17, 10);
      writeEntry(30, 10);
      runSearch(10, lat);
      checkOutput("ka_latency", lat, LAT_C2);
      checkOutput("ka_hit",     {31'b0, hit},    32'd1);
      checkOutput("ka_hit_idx", {27'b0, hit_idx}, 32'd17);
`ifdef ARRAY_SEARCH_COUNT_EN
      checkOutput("ka_hit_cnt", {26'b0, hit_cnt}, 32'd2);
`endif
      tick();

      // write and start during SCAN: write dropped with wr_err, start ignored
      applyStimulus(1'b0, '0, '0, 1'b1, 4'hA);
      tick();
      applyStimulus(1'b1, 5'd17, 4'h0, 1'b1, 4'h3);
      #1;
      checkOutput("scan_wr_err", {31'b0, wr_err}, 32'd1);
      tick();
      applyStimulus(1'b0, '0, '0, 1'b0, '0);
      #1;
      checkOutput("scan_wr_err_end", {31'b0, wr_err}, 32'd0);
      lat = 2;
      waitDone(lat);
      checkOutput("scan_wr_latency", lat, LAT_C2);
      checkOutput("scan_wr_hit_idx", {27'b0, hit_idx}, 32'd17);
      done_seen = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (done === 1'b1) done_seen++;
      end
      checkOutput("scan_no_extra_done", done_seen, 32'd0);

      // write entry 4 = 5 together with start key 5: search sees old value 0
      applyStimulus(1'b1, 5'd4, 4'h5, 1'b1, 4'h5);
      tick();
      applyStimulus(1'b0, '0, '0, 1'b0, '0);
      checkOutput("hold_hit",     {31'b0, hit},    32'd1);
      checkOutput("hold_hit_idx", {27'b0, hit_idx}, 32'd17);
      lat = 1;
      waitDone(lat);
      checkOutput("samecyc_latency", lat, LAT_MISS);
      checkOutput("samecyc_hit",     {31'b0, hit}, 32'd0);
      tick();
      runSearch(5, lat);
      checkOutput("newval_latency", lat, LAT_C0);
      checkOutput("newval_hit",     {31'b0, hit},    32'd1);
      checkOutput("newval_hit_idx", {27'b0, hit_idx}, 32'd4);
`ifdef ARRAY_SEARCH_COUNT_EN
      checkOutput("newval_hit_cnt", {26'b0, hit_cnt}, 32'd1);
`endif
      tick();

      // reset at N+2 of a scan, released at N+4: no done, table cleared
      applyStimulus(1'b0, '0, '0, 1'b1, 4'hA);
      tick();
      applyStimulus(1'b0, '0, '0, 1'b0, '0);
      tick();
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_busy", {31'b0, busy}, 32'd0);
      checkOutput("midrst_hit",  {31'b0, hit},  32'd0);
      done_seen = (done === 1'b1) ? 1 : 0;
      tick();
      if (done === 1'b1) done_seen++;
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (done === 1'b1) done_seen++;
      end
      checkOutput("midrst_no_done", done_seen, 32'd0);
      runSearch(0, lat);
      checkOutput("postrst_latency", lat, LAT_C0);
      checkOutput("postrst_hit",     {31'b0, hit},    32'd1);
      checkOutput("postrst_hit_idx", {27'b0, hit_idx}, 32'd0);
`ifdef ARRAY_SEARCH_COUNT_EN
      checkOutput("postrst_hit_cnt", {26'b0, hit_cnt}, 32'd32);
`endif
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
